icache_line_fill: RTL

- Memory-side refill engine directly downstream of the instruction cache controller.
- Converts a single-line refill request (icache2mem_req) into BEATS sequential narrow bus reads and assembles them into one cache line.
- Returns the line with a one-cycle mem2icache_ack pulse.
- Handles request withdrawal (fetch kill, boot-region PC) without abandoning an outstanding bus beat.

---
 rtl/icache_line_fill.sv | 124 ++++++++++++
 1 files changed

// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - instruction cache line refill engine over a narrow read bus
module icache_line_fill #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  icache2mem_req_i,
    input  logic [ADDR_WIDTH-1:0] icache2mem_addr_i,
    output logic                  mem2icache_ack_o,
    output logic [LINE_WIDTH-1:0] mem2icache_data_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [BUS_WIDTH-1:0]  mem_rdata_i
);

    localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int BOFF_W = $clog2(BUS_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [LINE_WIDTH-1:0] r_buf;

    logic                  w_load;
    logic                  w_write;
    logic                  w_inc;
    logic                  w_last;

    // The byte offset within the line is dropped when the base is latched.
    logic                  w_unused_addr;
    assign w_unused_addr = ^icache2mem_addr_i[OFF_W-1:0];

    assign w_last = (r_beat_cnt == CNT_W'(BEATS - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; a withdrawal in FILL always wins over beat capture.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_write     = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (icache2mem_req_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (!icache2mem_req_i) begin
                    w_state_nxt = mem_ack_i ? IDLE : DRAIN;
                end else if (mem_ack_i) begin
                    w_write = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    w_state_nxt = IDLE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line base, beat counter and line buffer; the buffer is never cleared between fills.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_base     <= '0;
            r_beat_cnt <= '0;
            r_buf      <= '0;
        end else begin
            if (w_load) begin
                r_base     <= {icache2mem_addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                r_beat_cnt <= '0;
            end else if (w_inc) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_write) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (r_beat_cnt == CNT_W'(b)) begin
                        r_buf[b*BUS_WIDTH +: BUS_WIDTH] <= mem_rdata_i;
                    end
                end
            end
        end
    end

    assign mem_req_o         = (r_state == FILL) || (r_state == DRAIN);
    assign mem_addr_o        = r_base + (ADDR_WIDTH'(r_beat_cnt) << BOFF_W);
    assign mem2icache_ack_o  = (r_state == DONE) && icache2mem_req_i;
    assign mem2icache_data_o = r_buf;

endmodule
